// File: rtl/adder_pkg.sv
// adder_pkg: shared definitions for the adder16 datapath family.
//   - state_t  : control FSM encoding used by the serial arithmetic blocks
//   - DEF_WIDTH: default operand/result width
//   - DEF_SLICE: default number of bits handled per clock by serial blocks
package adder_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SLICE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/subtractor16_serial_sub_slice.sv
// sub_slice: combinational SLICE-bit ripple-borrow subtractor.
// Ports:
//   a    [SLICE-1:0] in  : minuend slice
//   b    [SLICE-1:0] in  : subtrahend slice
//   bin              in  : borrow into bit 0
//   d    [SLICE-1:0] out : a - b - bin (slice-local)
//   bout             out : borrow out of the top bit
module sub_slice
  import adder_pkg::*;
#(
  parameter int SLICE = DEF_SLICE
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             bin,
  output logic [SLICE-1:0] d,
  output logic             bout
);

  logic [SLICE:0] chain_s;

  // Per-bit full-subtractor chain: borrow ripples from bit 0 upward.
  always_comb begin
    chain_s    = '0;
    d          = '0;
    chain_s[0] = bin;
    for (int i = 0; i < SLICE; i++) begin
      d[i]         = a[i] ^ b[i] ^ chain_s[i];
      // Borrow when a bit is 0 against 1, or bits equal and a borrow arrives.
      chain_s[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & chain_s[i]);
    end
    bout = chain_s[SLICE];
  end

endmodule

// File: rtl/subtractor16_serial.sv
// subtractor16_serial: multi-cycle two's-complement subtractor.
// Computes diff = a - b - bin (mod 2^WIDTH), SLICE bits per clock through a
// single ripple-borrow slice, with valid/ready handshakes on both sides.
// Ports:
//   clk        in  : rising-edge clock
//   rst        in  : asynchronous active-high reset
//   in_valid   in  : a, b, bin valid
//   in_ready   out : block can accept operands (IDLE only)
//   a, b [W]   in  : minuend, subtrahend
//   bin        in  : borrow in
//   out_valid  out : result registers hold a valid result (DONE)
//   out_ready  in  : consumer accepts the result
//   diff [W]   out : a - b - bin
//   bout       out : borrow out (unsigned a < b + bin)
//   ovf        out : signed overflow of the subtraction
module subtractor16_serial
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NSLICE - 1);

  state_t           state_r;
  state_t           state_next_s;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             borrow_r;
  logic [WIDTH-1:0] diff_r;
  logic             bout_r;
  logic             ovf_r;

  logic [SLICE-1:0] slice_a_s;
  logic [SLICE-1:0] slice_b_s;
  logic [SLICE-1:0] slice_d_s;
  logic             slice_bout_s;
  logic             last_slice_s;
  logic             in_ready_s;
  logic             out_valid_s;

  // Select the operand slice addressed by the counter.
  always_comb begin
    slice_a_s    = a_r[int'(cnt_r)*SLICE +: SLICE];
    slice_b_s    = b_r[int'(cnt_r)*SLICE +: SLICE];
    last_slice_s = (cnt_r == LAST_CNT);
  end

  sub_slice #(
    .SLICE (SLICE)
  ) u_sub_slice (
    .a    (slice_a_s),
    .b    (slice_b_s),
    .bin  (borrow_r),
    .d    (slice_d_s),
    .bout (slice_bout_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_next_s = BUSY;
        end else begin
          state_next_s = IDLE;
        end
      end
      BUSY: begin
        if (last_slice_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = BUSY;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // FSM outputs: handshake flags decoded from the state register.
  // in_ready is also gated by rst so it drops immediately on reset.
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready_s  = ~rst;
        out_valid_s = 1'b0;
      end
      BUSY: begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
      end
      DONE: begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b1;
      end
      default: begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
      end
    endcase
  end

  // Datapath: operand latch, slice counter, borrow chain and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r      <= '0;
      b_r      <= '0;
      borrow_r <= 1'b0;
      cnt_r    <= '0;
      diff_r   <= '0;
      bout_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            borrow_r <= bin;
            cnt_r    <= '0;
          end
        end
        BUSY: begin
          diff_r[int'(cnt_r)*SLICE +: SLICE] <= slice_d_s;
          borrow_r <= slice_bout_s;
          cnt_r    <= cnt_r + CW'(1);
          if (last_slice_s) begin
            bout_r <= slice_bout_s;
            // Overflow only when operand signs differ and the result sign
            // disagrees with the minuend; the top slice supplies diff's MSB.
            ovf_r  <= (a_r[WIDTH-1] != b_r[WIDTH-1]) &&
                      (slice_d_s[SLICE-1] != a_r[WIDTH-1]);
          end
        end
        DONE: begin
          cnt_r <= cnt_r;
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_s;
  assign diff      = diff_r;
  assign bout      = bout_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_subtractor16_serial.sv
// Self-checking bench for subtractor16_serial: directed and random operations
// checked against an arithmetic reference model, plus back-pressure and
// mid-operation reset scenarios.
module tb_subtractor16_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        bout;
  logic        ovf;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  subtractor16_serial dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  task automatic model(input logic [15:0] ma, input logic [15:0] mb, input logic mbin,
                       output logic [15:0] ed, output logic eb, output logic eo);
    logic [16:0] r;
    int          s;
    r  = {1'b0, ma} - {1'b0, mb} - {16'd0, mbin};
    ed = r[15:0];
    eb = r[16];
    s  = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
    eo = (s > 32767) || (s < -32768);
  endtask

  // Present operands at a negedge, take the accepting edge, then scramble inputs.
  task automatic accept(input logic [15:0] ta, input logic [15:0] tb, input logic tbin);
    in_valid = 1'b1;
    a = ta;
    b = tb;
    bin = tbin;
    chk("accept_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a   = 16'($urandom);
    b   = 16'($urandom);
    bin = 1'($urandom);
    @(negedge clk);
  endtask

  // From the negedge after acceptance: check latency, busy flags, and result.
  task automatic wait_result(input logic [15:0] ta, input logic [15:0] tb, input logic tbin);
    logic [15:0] ed;
    logic        eb;
    logic        eo;
    int          n;
    n = 0;
    chk("busy_in_ready", in_ready, 0);
    chk("busy_out_valid", out_valid, 0);
    for (int i = 1; i <= 8; i++) begin
      if (n == 0) begin
        in_valid = 1'($urandom);
        a = 16'($urandom);
        b = 16'($urandom);
        @(posedge clk);
        @(negedge clk);
        if (out_valid === 1'b1) begin
          n = i;
        end else begin
          chk("busy_in_ready", in_ready, 0);
        end
      end
    end
    in_valid = 1'b0;
    chk("latency", n, 4);
    model(ta, tb, tbin, ed, eb, eo);
    chk("diff", diff, ed);
    chk("bout", bout, eb);
    chk("ovf", ovf, eo);
    chk("done_in_ready", in_ready, 0);
  endtask

  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tbin);
    out_ready = 1'b1;
    accept(ta, tb, tbin);
    wait_result(ta, tb, tbin);
    @(posedge clk);
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);
  endtask

  initial begin
    logic [15:0] d0;
    logic        b0;
    logic        o0;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rbin;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = 16'h0000;
    b = 16'h0000;
    bin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    @(negedge clk);

    // Directed vectors.
    run_op(16'h1234, 16'h0034, 1'b0);
    chk("dir_1234_diff", diff, 16'h1200);
    run_op(16'h0000, 16'h0001, 1'b0);
    chk("dir_wrap_diff", diff, 16'hFFFF);
    chk("dir_wrap_bout", bout, 1);
    run_op(16'h8000, 16'h0001, 1'b0);
    chk("dir_ovf1_diff", diff, 16'h7FFF);
    chk("dir_ovf1", ovf, 1);
    run_op(16'h7FFF, 16'hFFFF, 1'b0);
    chk("dir_ovf2_diff", diff, 16'h8000);
    chk("dir_ovf2", ovf, 1);
    run_op(16'h0005, 16'h0005, 1'b1);
    chk("dir_chain_diff", diff, 16'hFFFF);
    chk("dir_chain_bout", bout, 1);

    // Random operations.
    for (int k = 0; k < 20; k++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rbin = 1'($urandom);
      run_op(ra, rb, rbin);
    end

    // Back-pressure: hold result in DONE while inputs wiggle.
    out_ready = 1'b0;
    ra = 16'hA5C3;
    rb = 16'h5A3C;
    accept(ra, rb, 1'b1);
    wait_result(ra, rb, 1'b1);
    d0 = diff;
    b0 = bout;
    o0 = ovf;
    for (int k = 0; k < 3; k++) begin
      in_valid = ~in_valid;
      a = 16'($urandom);
      b = 16'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_diff", diff, d0);
      chk("bp_bout", bout, b0);
      chk("bp_ovf", ovf, o0);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    a = 16'h0100;
    b = 16'h0200;
    bin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    @(negedge clk);
    wait_result(16'h0100, 16'h0200, 1'b0);
    chk("bp_next_diff", diff, 16'hFF00);
    @(posedge clk);
    @(negedge clk);

    // Reset in the middle of BUSY after two slices.
    out_ready = 1'b1;
    accept(16'h1234, 16'h4321, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_diff", diff, 0);
    chk("mid_rst_bout", bout, 0);
    chk("mid_rst_ovf", ovf, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("after_rst_in_ready", in_ready, 1);
    chk("after_rst_out_valid", out_valid, 0);
    @(negedge clk);
    run_op(16'h0010, 16'h0001, 1'b0);
    chk("after_rst_diff", diff, 16'h000F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/subtractor16_serial.md
Name: subtractor16_serial

Overview:
Multi-cycle two's-complement subtractor for the adder16 datapath family. It computes diff = a - b - bin over WIDTH bits, processing SLICE bits per clock through one ripple-borrow slice. A valid/ready handshake sits on both the operand side and the result side. It is the area-lean inverse-arithmetic companion to the ripple-carry adders.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of SLICE.
SLICE, 4, bits processed per clock; NSLICE = WIDTH/SLICE cycles per operation.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operands a, b, bin are valid
in_ready  output  1  block can accept operands
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
bin  input  1  borrow in
out_valid  output  1  result registers hold a valid result
out_ready  input  1  consumer accepts the result
diff  output  WIDTH  a - b - bin, modulo 2^WIDTH
bout  output  1  borrow out; 1 when unsigned a < b + bin
ovf  output  1  signed overflow of the subtraction

Behaviour:
- Reset: asynchronous and active-high. While rst=1: state=IDLE, in_ready=0, out_valid=0, diff=0, bout=0, ovf=0, slice counter=0, and operand registers cleared. The first edge after release sees in_ready=1.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. If in_valid=1 at an edge, latch a, b, and bin (internal borrow=bin), clear the slice counter, and move to BUSY.
  - BUSY: in_ready=0. At each edge, slice k=counter computes a[k] + ~b[k] + ~borrow. The slice result is written into diff[k*SLICE +: SLICE], and borrow is updated to ~carry_out. The counter increments. On the edge that processes slice NSLICE-1, move to DONE.
  - DONE: out_valid=1, in_ready=0, and diff/bout/ovf held stable. If out_ready=1 at an edge, move to IDLE with out_valid=0. diff/bout/ovf keep their last values until the next operation overwrites them.
- Latency: with acceptance at edge 0, out_valid is high after edge NSLICE (4 for the defaults). Minimum initiation interval is NSLICE+2 cycles.
- bout = final borrow. ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), computed from the latched operands at the final slice.
- Inputs are ignored outside IDLE. in_valid pulses during BUSY/DONE have no effect, and operand changes after acceptance do not affect the result.
- out_ready is ignored outside DONE.
- Reset asserted mid-BUSY or mid-DONE aborts the operation with no partial output. Everything returns to its reset values immediately; no state edge is needed.
- Arithmetic is modulo 2^WIDTH. No saturation.

Decomposition:
- Shared package (adder_pkg): FSM state enum {IDLE, BUSY, DONE}, and the default WIDTH/SLICE constants.
- One sub-module: sub_slice, a combinational SLICE-bit ripple-borrow subtractor.
  - Inputs: a, b, bin. Outputs: d, bout.
  - Built from per-bit full-subtractor equations and instantiated once in the top.
- The top contains the FSM, slice counter, operand shift/latch registers, and result registers.

Test Plan:
- a=16'h1234, b=16'h0034, bin=0, out_ready=1 -> after 4 edges out_valid=1, diff=16'h1200, bout=0, ovf=0; in_ready=0 for the whole operation.
- a=16'h0000, b=16'h0001, bin=0 -> diff=16'hFFFF, bout=1, ovf=0.
- a=16'h8000, b=16'h0001, bin=0 -> diff=16'h7FFF, bout=0, ovf=1; also a=16'h7FFF, b=16'hFFFF -> diff=16'h8000, bout=1, ovf=1.
- a=16'h0005, b=16'h0005, bin=1 -> diff=16'hFFFF, bout=1, ovf=0; a borrow chain crossing all 4 slices is confirmed.
- Back-pressure: hold out_ready=0 for 3 cycles in DONE while toggling in_valid and changing a/b -> out_valid, diff, bout, and ovf are stable and no new operation starts. Raise out_ready -> IDLE next edge, and a new operation is accepted the following edge.
- Pulse rst during BUSY after 2 slices -> out_valid=0, diff=0, bout=0, ovf=0, in_ready=0 asynchronously. After release, in_ready=1, and a=16'h0010, b=16'h0001 yields diff=16'h000F.
